// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    StIdle,
    StPrepare,
    StDivide,
    StFinish
  } div_state_e;

  // Quotient on divide-by zero is all ones at any width (RISC-V M).
  localparam logic DIV_ZERO_FILL = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_restoring_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted  = {rem_in, dividend_msb};
    diff     = shifted - {1'b0, divisor};
    quot_bit = ~diff[WIDTH];
    // Partial remainder stays below the divisor, so the restored value fits in WIDTH bits.
    rem_out  = quot_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_int_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour signed_i; otherwise every operation is unsigned.
module seq_int_divider
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_valid_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  divide_by_zero_o,
  output logic                  data_valid_o
);

  localparam int unsigned CntW = cnt_width(DATA_WIDTH);

  div_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d, remr_q, remr_d;
  logic                  dbz_q, dbz_d, valid_q, valid_d;

  logic [DATA_WIDTH-1:0] a_abs, b_abs, quot_fix, rem_fix, step_rem;
  logic                  step_bit;

`ifdef DIV_SIGNED_EN
  logic sgn_q, sgn_d;

  assign a_abs    = (sgn_q && a_q[DATA_WIDTH-1]) ? -a_q : a_q;
  assign b_abs    = (sgn_q && b_q[DATA_WIDTH-1]) ? -b_q : b_q;
  assign quot_fix = (sgn_q && (a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1])) ? -dvd_q : dvd_q;
  assign rem_fix  = (sgn_q && a_q[DATA_WIDTH-1]) ? -rem_q : rem_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sgn_q <= 1'b0;
    else       sgn_q <= sgn_d;
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign a_abs         = a_q;
  assign b_abs         = b_q;
  assign quot_fix      = dvd_q;
  assign rem_fix       = rem_q;
`endif

  div_restoring_step #(
    .WIDTH(DATA_WIDTH)
  ) u_step (
    .rem_in      (rem_q),
    .dividend_msb(dvd_q[DATA_WIDTH-1]),
    .divisor     (b_abs),
    .rem_out     (step_rem),
    .quot_bit    (step_bit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      quot_q  <= '0;
      remr_q  <= '0;
      dbz_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      quot_q  <= quot_d;
      remr_q  <= remr_d;
      dbz_q   <= dbz_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quot_d  = quot_q;
    remr_d  = remr_q;
    dbz_d   = dbz_q;
    valid_d = 1'b0;
`ifdef DIV_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (data_valid_i) begin
          a_d     = dividend_i;
          b_d     = divisor_i;
`ifdef DIV_SIGNED_EN
          sgn_d   = signed_i;
`endif
          state_d = StPrepare;
        end
      end
      StPrepare: begin
        if (b_q == '0) begin
          dbz_d   = 1'b1;
          state_d = StFinish;
        end else begin
          dbz_d   = 1'b0;
          dvd_d   = a_abs;
          rem_d   = '0;
          cnt_d   = CntW'(DATA_WIDTH - 1);
          state_d = StDivide;
        end
      end
      StDivide: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[DATA_WIDTH-2:0], step_bit};
        if (cnt_q == '0) state_d = StFinish;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StFinish: begin
        if (dbz_q) begin
          quot_d = {DATA_WIDTH{DIV_ZERO_FILL}};
          remr_d = a_q;
        end else begin
          quot_d = quot_fix;
          remr_d = rem_fix;
        end
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ready_o          = (state_q == StIdle);
  assign quotient_o       = quot_q;
  assign remainder_o      = remr_q;
  assign divide_by_zero_o = dbz_q;
  assign data_valid_o     = valid_q;

endmodule

// File: tb/tb_seq_int_divider.sv
// Self-checking bench for seq_int_divider: directed table, multi-cycle corners, random vs model.
module tb_seq_int_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        ready_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        divide_by_zero_o;
  logic        data_valid_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_int_divider #(
    .DATA_WIDTH(32)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .data_valid_i    (data_valid_i),
    .signed_i        (signed_i),
    .dividend_i      (dividend_i),
    .divisor_i       (divisor_i),
    .ready_o         (ready_o),
    .quotient_o      (quotient_o),
    .remainder_o     (remainder_o),
    .divide_by_zero_o(divide_by_zero_o),
    .data_valid_o    (data_valid_o)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic plus the RISC-V M corner-case rules.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic dbz);
    logic eff_signed;
`ifdef DIV_SIGNED_EN
    eff_signed = s;
`else
    eff_signed = 1'b0;
    if (s) eff_signed = 1'b0;
`endif
    dbz = (b == 32'd0);
    if (dbz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (eff_signed) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic dbz,
                       output int lat);
    @(negedge clk);
    check("ready before accept", ready_o, 1);
    data_valid_i = 1'b1;
    dividend_i   = a;
    divisor_i    = b;
    signed_i     = s;
    @(posedge clk);
    @(negedge clk);
    data_valid_i = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (data_valid_o) break;
    end
    q   = quotient_o;
    r   = remainder_o;
    dbz = divide_by_zero_o;
    @(negedge clk);
    check("valid pulse width", data_valid_o, 0);
  endtask

  initial begin
    logic [31:0] q, r, eq, er;
    logic        dbz, edbz;
    int          lat, seen;

    rst          = 1'b1;
    data_valid_i = 1'b0;
    signed_i     = 1'b0;
    dividend_i   = '0;
    divisor_i    = '0;
    repeat (3) @(negedge clk);
    check("reset ready", ready_o, 1);
    check("reset quotient", quotient_o, 0);
    check("reset remainder", remainder_o, 0);
    check("reset dbz", divide_by_zero_o, 0);
    check("reset valid", data_valid_o, 0);
    rst = 1'b0;

    tbl.push_back('{"100/7 u", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34});
    tbl.push_back('{"5/0 u", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2});
    tbl.push_back('{"5/0 s", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 2});
    tbl.push_back('{"-7/2 u", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 34});
`ifdef DIV_SIGNED_EN
    tbl.push_back('{"-7/2 s", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34});
    tbl.push_back('{"min/-1 s", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0,
                    34});
`else
    tbl.push_back('{"-7/2 s", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 34});
    tbl.push_back('{"min/-1 s", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0,
                    34});
`endif
    tbl.push_back('{"0/5 u", 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 34});
    tbl.push_back('{"9/9 u", 32'd9, 32'd9, 1'b0, 32'd1, 32'd0, 1'b0, 34});
    tbl.push_back('{"3/8 u", 32'd3, 32'd8, 1'b0, 32'd0, 32'd3, 1'b0, 34});

    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].s, q, r, dbz, lat);
      check({tbl[i].name, " quotient"}, q, tbl[i].q);
      check({tbl[i].name, " remainder"}, r, tbl[i].r);
      check({tbl[i].name, " dbz"}, dbz, tbl[i].dbz);
      check({tbl[i].name, " latency"}, lat, tbl[i].lat);
    end

    // Reset ten cycles into the divide loop: outputs clear at once, no result escapes.
    @(negedge clk);
    data_valid_i = 1'b1;
    dividend_i   = 32'h1234_5678;
    divisor_i    = 32'd3;
    signed_i     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    data_valid_i = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort ready", ready_o, 1);
    check("abort quotient", quotient_o, 0);
    check("abort remainder", remainder_o, 0);
    check("abort dbz", divide_by_zero_o, 0);
    check("abort valid", data_valid_o, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (data_valid_o) seen++;
    end
    check("abort no result", seen, 0);
    do_op(32'hFFFF_FFFF, 32'h10, 1'b0, q, r, dbz, lat);
    check("post-abort quotient", q, 32'h0FFF_FFFF);
    check("post-abort remainder", r, 32'hF);
    check("post-abort latency", lat, 34);

    // Back-to-back: valid held through busy, second op taken in the result cycle.
    @(negedge clk);
    data_valid_i = 1'b1;
    dividend_i   = 32'd100;
    divisor_i    = 32'd7;
    signed_i     = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy ready low", ready_o, 0);
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (data_valid_o) break;
    end
    check("b2b first latency", lat, 34);
    check("b2b first quotient", quotient_o, 32'd14);
    check("b2b first remainder", remainder_o, 32'd2);
    check("b2b ready in valid cycle", ready_o, 1);
    @(posedge clk);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (data_valid_o) break;
      @(posedge clk);
      lat++;
    end
    data_valid_i = 1'b0;
    check("b2b second latency", lat, 34);
    check("b2b second quotient", quotient_o, 32'd333);
    check("b2b second remainder", remainder_o, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (data_valid_o) seen++;
    end
    check("b2b no extra result", seen, 0);

    // Randomised operands against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom();
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom() >> $urandom_range(0, 31);
      endcase
      s = 1'($urandom_range(0, 1));
      model(a, b, s, eq, er, edbz);
      do_op(a, b, s, q, r, dbz, lat);
      check("rand quotient", q, eq);
      check("rand remainder", r, er);
      check("rand dbz", dbz, edbz);
      check("rand latency", lat, edbz ? 2 : 34);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
